// File: rtl/fir_sink_feeder.sv
`default_nettype none
// ============================================================================
// Module      : fir_sink_feeder
// Description : Input-side companion to the FIR output saturator. Buffers
//               free-running ADC samples and feeds them to the FIR
//               Avalon-ST sink under ready backpressure. When the requested
//               filter select changes, it drains the FIR delay line with
//               zero samples and then publishes the new select atomically
//               on sel_active.
// Config      : FIR_SINK_FEEDER_FLUSH_EN
//                 defined   - FLUSH_LEN zero samples are emitted before each
//                             select switch.
//                 undefined - the select switch costs one bubble cycle and
//                             no zeros are emitted. FLUSH_LEN is unused.
// Ports       : clk               rising-edge clock
//               reset             asynchronous active-high reset
//               sel               requested filter (0 flat,1 LP,2 BP,3 HP)
//               in_data/in_valid  ADC sample stream (cannot be stalled)
//               ovf_clr           clears the sticky overflow flag
//               ast_source_*      Avalon-ST source to FIR (ready latency 0),
//                                 error=01 marks the first sample after drops
//               sel_active        select currently applied downstream
//               flushing          high while flushing or switching select
//               overflow          sticky: at least one sample was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sink_feeder #(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int FLUSH_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] ast_source_data,
  output logic                  ast_source_valid,
  input  logic                  ast_source_ready,
  output logic [1:0]            ast_source_error,
  output logic [1:0]            sel_active,
  output logic                  flushing,
  output logic                  overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_RUN    = 2'd0;
`ifdef FIR_SINK_FEEDER_FLUSH_EN
  localparam logic [1:0] ST_FLUSH  = 2'd1;
`endif
  localparam logic [1:0] ST_SWITCH = 2'd2;

  // Reject parameterisations the pointer arithmetic cannot support.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      FLUSH_LEN < 1 || DATA_WIDTH < 1) begin : g_param_check
    $error("fir_sink_feeder: invalid parameterisation");
  end

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  // Each entry stores {dropped-before flag, sample}.
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                pending_err;

  logic                head_valid;
  logic                xfer;
  logic                pop;
  logic                push;
  logic                drop;
  logic                sel_change;

  // The FIFO head is the output stage: a sample written into an empty FIFO
  // is presented on the very next cycle, and it counts toward FIFO_DEPTH.
  assign head_valid = (state == ST_RUN) && (count != '0);
  assign xfer       = ast_source_valid && ast_source_ready;
  assign pop        = head_valid && ast_source_ready;
  assign push       = in_valid && ((count != DEPTH_C) || pop);
  assign drop       = in_valid && !push;

  // Only leave RUN when nothing is left pending on the output, so a
  // presented sample is never withdrawn.
  assign sel_change = (state == ST_RUN) && (sel != sel_active) &&
                      (!ast_source_valid || xfer);

  assign ast_source_data  = head_valid ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
  assign ast_source_error = head_valid ? {1'b0, mem[rd_ptr][DATA_WIDTH]} : 2'b00;
  assign flushing         = (state != ST_RUN);

`ifdef FIR_SINK_FEEDER_FLUSH_EN
  localparam int FCNT_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_LEN - 1);

  logic [FCNT_W-1:0] flush_cnt;

  // Flush zeros are driven continuously; data/error stay at zero.
  assign ast_source_valid = head_valid || (state == ST_FLUSH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt <= '0;
    end else if ((state == ST_FLUSH) && xfer) begin
      // Returns to zero on the final zero, ready for the next flush.
      flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + 1'b1;
    end
  end
`else
  assign ast_source_valid = head_valid;
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (sel_change) begin
`ifdef FIR_SINK_FEEDER_FLUSH_EN
          state_nxt = ST_FLUSH;
`else
          state_nxt = ST_SWITCH;
`endif
        end
      end
`ifdef FIR_SINK_FEEDER_FLUSH_EN
      ST_FLUSH: begin
        if (xfer && (flush_cnt == FLUSH_LAST)) begin
          state_nxt = ST_SWITCH;
        end
      end
`endif
      ST_SWITCH: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      sel_active <= 2'd0;
    end else begin
      state <= state_nxt;
      // Latest requested select is taken here, even if it changed again
      // during the flush (possibly back to the old value).
      if (state == ST_SWITCH) begin
        sel_active <= sel;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sample FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {pending_err, in_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Drop tracking: the flag rides on the next sample that gets in.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow    <= 1'b0;
      pending_err <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      if (drop) begin
        pending_err <= 1'b1;
      end else if (push) begin
        pending_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_sink_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_sink_feeder
// Description : Self-checking bench for fir_sink_feeder. Stimulus queues the
//               expected transfer sequence; a monitor pops and compares on
//               every Avalon-ST transfer. Build with FIR_SINK_FEEDER_FLUSH_EN
//               to exercise the flush scenarios, without it for the
//               bubble-only select switch.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fir_sink_feeder;

  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int FLEN  = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    sel;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          ovf_clr;
  logic [DW-1:0] ast_source_data;
  logic          ast_source_valid;
  logic          ast_source_ready;
  logic [1:0]    ast_source_error;
  logic [1:0]    sel_active;
  logic          flushing;
  logic          overflow;

  fir_sink_feeder #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .FLUSH_LEN (FLEN)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sel             (sel),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .ovf_clr         (ovf_clr),
    .ast_source_data (ast_source_data),
    .ast_source_valid(ast_source_valid),
    .ast_source_ready(ast_source_ready),
    .ast_source_error(ast_source_error),
    .sel_active      (sel_active),
    .flushing        (flushing),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    err;
    bit            is_zero;
    bit            last;
    logic [1:0]    nsel;
    bit            chk_lat;
    int            pcyc;
  } item_t;

  item_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [1:0]    prev_err;
  int            post_cnt = 0;
  logic [1:0]    post_sel;
  int            zeros_seen = 0;
  item_t         it;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      post_cnt   = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(ast_source_valid), 32'd1);
        check("hold_data",  32'(ast_source_data),  32'(prev_data));
        check("hold_error", 32'(ast_source_error), 32'(prev_err));
      end
      if (post_cnt == 1) begin
        check("switch_bubble_valid", 32'(ast_source_valid), 32'd0);
        check("switch_flushing",     32'(flushing),         32'd1);
        post_cnt = 2;
      end else if (post_cnt == 2) begin
        check("sel_active_after_flush", 32'(sel_active), 32'(post_sel));
        check("flushing_cleared",       32'(flushing),   32'd0);
        post_cnt = 0;
      end
      if (ast_source_valid && ast_source_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: got data %0h, expected no transfer", ast_source_data);
        end else begin
          it = exp_q.pop_front();
          check("xfer_data",  32'(ast_source_data),  32'(it.data));
          check("xfer_error", 32'(ast_source_error), 32'(it.err));
          if (it.chk_lat) check("latency", 32'(cyc), 32'(it.pcyc + 1));
          if (it.is_zero) zeros_seen++;
          if (it.last) begin
            post_cnt = 1;
            post_sel = it.nsel;
          end
        end
      end
      prev_stall = ast_source_valid && !ast_source_ready;
      prev_data  = ast_source_data;
      prev_err   = ast_source_error;
    end
  end

  // --------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample for the current cycle and record what must come out.
  task automatic push_sample(input logic [DW-1:0] d, input logic [1:0] e, input bit lat);
    item_t x;
    in_valid = 1'b1;
    in_data  = d;
    x = '{data: d, err: e, is_zero: 1'b0, last: 1'b0, nsel: 2'd0, chk_lat: lat, pcyc: cyc};
    exp_q.push_back(x);
  endtask

  // A select change is expected to produce FLEN zeros, the last one tagged
  // with the select that must appear afterwards.
  task automatic expect_flush(input logic [1:0] nsel);
    item_t x;
    for (int i = 0; i < FLEN; i++) begin
      x = '{data: '0, err: 2'b00, is_zero: 1'b1, last: (i == FLEN - 1), nsel: nsel,
            chk_lat: 1'b0, pcyc: 0};
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || post_cnt != 0) && n < limit) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || post_cnt != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d items left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},      32'(ast_source_valid), 32'd0);
    check({tag, "_data"},       32'(ast_source_data),  32'd0);
    check({tag, "_error"},      32'(ast_source_error), 32'd0);
    check({tag, "_sel_active"}, 32'(sel_active),       32'd0);
    check({tag, "_flushing"},   32'(flushing),         32'd0);
    check({tag, "_overflow"},   32'(overflow),         32'd0);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    int base;
    int n;
    reset            = 1'b1;
    sel              = 2'd0;
    in_data          = '0;
    in_valid         = 1'b0;
    ovf_clr          = 1'b0;
    ast_source_ready = 1'b1;
    #1;
    check_all_zero("reset");
    tick(); tick();
    reset = 1'b0;
    tick();

    // Ordered stream with ready high: one-cycle latency, no errors.
    for (int i = 1; i <= 30; i++) begin
      push_sample(DW'(i), 2'b00, 1'b1);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b0;
      if ($urandom_range(1, 0) == 1) push_sample(DW'($urandom), 2'b00, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    wait_drain("stream", 50);
    check("stream_overflow", 32'(overflow), 32'd0);

    // Random backpressure with bursts that never exceed the buffer.
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (n < DEPTH) begin
        ast_source_ready = 1'($urandom_range(1, 0));
        in_valid = 1'b0;
        if ($urandom_range(2, 0) != 0) begin
          push_sample(DW'($urandom), 2'b00, 1'b0);
          n++;
        end
        tick();
      end
      in_valid = 1'b0;
      ast_source_ready = 1'b1;
      wait_drain("burst", 100);
    end
    check("burst_overflow", 32'(overflow), 32'd0);

    // Stall 20 cycles: first DEPTH kept, the rest dropped.
    ast_source_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(12'h100 + i);
      if (i < DEPTH) push_sample(DW'(12'h100 + i), 2'b00, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("stall_overflow_set", 32'(overflow), 32'd1);
    ast_source_ready = 1'b1;
    wait_drain("stall", 50);
    push_sample(12'h7AA, 2'b01, 1'b1);
    tick();
    push_sample(12'h155, 2'b00, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_drain("after_drop", 20);
    check("overflow_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("overflow_cleared", 32'(overflow), 32'd0);

`ifdef FIR_SINK_FEEDER_FLUSH_EN
    // Select 0 -> 2: 64 zeros, then buffered samples untouched.
    sel = 2'd2;
    expect_flush(2'd2);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b0;
      if (i >= 10 && i < 15) push_sample(DW'($urandom), 2'b00, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    wait_drain("flush_0_2", 300);
    check("sel_active_2", 32'(sel_active), 32'd2);

    // Select 2 -> 3 -> 1 with 50% backpressure during the flush.
    sel = 2'd3;
    expect_flush(2'd1);
    n = 0;
    while ((exp_q.size() != 0 || post_cnt != 0) && n < 1000) begin
      ast_source_ready = 1'($urandom_range(1, 0));
      in_valid = 1'b0;
      if (n == 40) sel = 2'd1;
      if (n >= 50 && n < 56) push_sample(DW'($urandom), 2'b00, 1'b0);
      tick();
      n++;
    end
    in_valid = 1'b0;
    ast_source_ready = 1'b1;
    wait_drain("flush_3_1", 100);
    check("sel_active_1", 32'(sel_active), 32'd1);
    check("flush_3_1_overflow", 32'(overflow), 32'd0);

    // Reset in the middle of a flush, then a fresh flush towards 3.
    base = zeros_seen;
    sel = 2'd2;
    expect_flush(2'd2);
    n = 0;
    while (zeros_seen < base + 30 && n < 200) begin
      tick();
      n++;
    end
    check("reached_zero_30", 32'(zeros_seen - base), 32'd30);
    reset = 1'b1;
    #1;
    check_all_zero("mid_flush_reset");
    exp_q.delete();
    sel = 2'd3;
    expect_flush(2'd3);
    tick(); tick();
    reset = 1'b0;
    wait_drain("flush_after_reset", 300);
    check("sel_active_3", 32'(sel_active), 32'd3);
`else
    // Select 0 -> 1: one bubble cycle, no zeros emitted.
    sel = 2'd1;
    @(negedge clk);
    check("sw_detect_flushing", 32'(flushing),   32'd0);
    check("sw_detect_sel",      32'(sel_active), 32'd0);
    @(negedge clk);
    check("sw_bubble_valid",    32'(ast_source_valid), 32'd0);
    check("sw_bubble_flushing", 32'(flushing),         32'd1);
    check("sw_bubble_sel",      32'(sel_active),       32'd0);
    @(negedge clk);
    check("sw_done_sel",        32'(sel_active), 32'd1);
    check("sw_done_flushing",   32'(flushing),   32'd0);
    tick();

    // Select change while streaming: samples survive unchanged and in order.
    for (int i = 0; i < 20; i++) begin
      if (i == 10) sel = 2'd2;
      push_sample(DW'($urandom), 2'b00, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    wait_drain("stream_switch", 50);
    check("sel_active_2", 32'(sel_active), 32'd2);
    check("stream_switch_overflow", 32'(overflow), 32'd0);
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
